// File: rtl/muxn_pkg.sv
// Shared definitions for the N-channel stream multiplexer: mode encodings
// and a one-hot to binary index helper.
package muxn_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Supports up to 16 channels; callers zero-extend narrower one-hot vectors.
    function automatic int unsigned onehot_to_idx(input logic [15:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr,
// wrapping past NCH-1 back to 0, receives the one-hot grant.
module rr_arbiter
    import muxn_pkg::*;
#(
    parameter int NCH = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] grant_idx,
    output logic            any_grant
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = (int'(ptr) + k) % NCH;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign grant_idx = SELW'(onehot_to_idx(16'(grant)));
    assign any_grant = |grant;

endmodule

// File: rtl/muxn_stream.sv
// N-channel valid/ready stream multiplexer with fixed-select or round-robin
// arbitration feeding a single registered output stage.
module muxn_stream
    import muxn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    input  logic                 out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic [NCH-1:0]   rr_grant;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;
    logic [NCH-1:0]   fix_grant;
    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  gidx;
    logic             space;
    logic             accept;
    logic [WIDTH-1:0] chan_data [NCH];
    logic [WIDTH-1:0] sel_data;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx),
        .any_grant (rr_any)
    );

    always_comb begin
        fix_grant = '0;
        if (int'(sel) < NCH) fix_grant[sel] = in_valid[sel];
    end

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign grant    = (mode == MODE_RR) ? rr_grant : fix_grant;
    assign gidx     = (mode == MODE_RR) ? rr_idx : sel;
    assign space    = ~out_valid_q | out_ready;
    assign in_ready = reset ? '0 : (grant & {NCH{space}});
    assign accept   = |(in_valid & in_ready);

    always_comb begin
        sel_data = '0;
        if (int'(gidx) < NCH) sel_data = chan_data[gidx];
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_chan_d  = gidx;
            if (mode == MODE_RR && rr_any) begin
                ptr_d = (int'(rr_idx) == NCH - 1) ? '0 : rr_idx + SELW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_muxn_stream.sv
// Directed bench for muxn_stream: a 4-channel and a 6-channel instance share
// clock and reset; expected values are hand-computed constants.
module tb_muxn_stream;

    logic        clk;
    logic        reset;

    logic        mode_a;
    logic [1:0]  sel_a;
    logic [3:0]  in_valid_a;
    logic [31:0] in_data_a;
    logic [3:0]  in_ready_a;
    logic        out_valid_a;
    logic [7:0]  out_data_a;
    logic [1:0]  out_chan_a;
    logic        out_ready_a;

    logic        mode_b;
    logic [2:0]  sel_b;
    logic [5:0]  in_valid_b;
    logic [47:0] in_data_b;
    logic [5:0]  in_ready_b;
    logic        out_valid_b;
    logic [7:0]  out_data_b;
    logic [2:0]  out_chan_b;
    logic        out_ready_b;

    int vectors;
    int miscompares;

    muxn_stream #(.WIDTH(8), .NCH(4)) dut_a (
        .clk(clk), .reset(reset), .mode(mode_a), .sel(sel_a),
        .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_chan(out_chan_a),
        .out_ready(out_ready_a)
    );

    muxn_stream #(.WIDTH(8), .NCH(6)) dut_b (
        .clk(clk), .reset(reset), .mode(mode_b), .sel(sel_b),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_chan(out_chan_b),
        .out_ready(out_ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] rr_exp [5];
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        vectors = 0;
        miscompares = 0;

        reset = 1'b1;
        mode_a = 1'b0; sel_a = 2'd2; in_valid_a = 4'b1111;
        in_data_a = {8'h44, 8'hC3, 8'h22, 8'h11}; out_ready_a = 1'b1;
        mode_b = 1'b0; sel_b = 3'd5; in_valid_b = '0; in_data_b = '0; out_ready_b = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_data", 32'(out_data_a), 32'd0);
        chk("rst_out_chan", 32'(out_chan_a), 32'd0);
        chk("rst_in_ready", 32'(in_ready_a), 32'd0);
        #10;
        reset = 1'b0;
        #1;

        // Fixed select, channel 2
        chk("fix_in_ready", 32'(in_ready_a), 32'b0100);
        tick;
        chk("fix_valid", 32'(out_valid_a), 32'd1);
        chk("fix_data", 32'(out_data_a), 32'hC3);
        chk("fix_chan", 32'(out_chan_a), 32'd2);
        in_data_a = {8'h44, 8'h3C, 8'h22, 8'h11};
        tick;
        chk("fix_data2", 32'(out_data_a), 32'h3C);
        chk("fix_valid2", 32'(out_valid_a), 32'd1);

        // Round robin, all channels requesting, pointer at 0
        mode_a = 1'b1;
        in_data_a = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        #1;
        chk("rr_in_ready0", 32'(in_ready_a), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("rr_chan", 32'(out_chan_a), 32'(rr_exp[k]));
            chk("rr_data", 32'(out_data_a), 32'hD0 + 32'(rr_exp[k]));
        end
        tick;
        chk("rr_chan_extra", 32'(out_chan_a), 32'd1);

        // Pointer now 2, only ch1/ch3 requesting
        in_valid_a = 4'b1010;
        #1;
        chk("rr2_ready_a", 32'(in_ready_a), 32'b1000);
        tick;
        chk("rr2_chan_a", 32'(out_chan_a), 32'd3);
        chk("rr2_ready_b", 32'(in_ready_a), 32'b0010);
        tick;
        chk("rr2_chan_b", 32'(out_chan_a), 32'd1);
        chk("rr2_ready_c", 32'(in_ready_a), 32'b1000);
        tick;
        chk("rr2_chan_c", 32'(out_chan_a), 32'd3);

        // Backpressure
        mode_a = 1'b0; sel_a = 2'd0; in_valid_a = 4'b0001;
        in_data_a = {8'h44, 8'h33, 8'h22, 8'h11};
        tick;
        chk("bp_load", 32'(out_data_a), 32'h11);
        out_ready_a = 1'b0; sel_a = 2'd1; in_valid_a = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready_a), 32'd0);
            tick;
            chk("bp_hold_data", 32'(out_data_a), 32'h11);
            chk("bp_hold_valid", 32'(out_valid_a), 32'd1);
        end
        out_ready_a = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready_a), 32'b0010);
        tick;
        chk("bp_next_data", 32'(out_data_a), 32'h22);
        chk("bp_next_chan", 32'(out_chan_a), 32'd1);

        // sel=3 with in_valid[3]=0: no grant, output drains, pointer untouched
        sel_a = 2'd3; in_valid_a = 4'b0111;
        #1;
        chk("nogrant_ready", 32'(in_ready_a), 32'd0);
        tick;
        chk("drain_valid", 32'(out_valid_a), 32'd0);
        chk("drain_data_held", 32'(out_data_a), 32'h22);
        chk("drain_chan_held", 32'(out_chan_a), 32'd1);
        mode_a = 1'b1; in_valid_a = 4'b1111;
        #1;
        chk("ptr_unchanged", 32'(in_ready_a), 32'b0001);
        in_valid_a = 4'b0000;

        // Six-channel instance: sel=5 legal, sel=7 out of range
        in_valid_b = 6'b100000;
        in_data_b = {8'hA5, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        #1;
        chk("b_ready_sel5", 32'(in_ready_b), 32'b100000);
        tick;
        chk("b_valid", 32'(out_valid_b), 32'd1);
        chk("b_data", 32'(out_data_b), 32'hA5);
        chk("b_chan", 32'(out_chan_b), 32'd5);
        sel_b = 3'd7; in_valid_b = 6'b111111;
        #1;
        chk("b_ready_sel7", 32'(in_ready_b), 32'd0);
        tick;
        chk("b_drain", 32'(out_valid_b), 32'd0);

        // Reset in the middle of a held beat
        mode_a = 1'b0; sel_a = 2'd0; in_valid_a = 4'b0001;
        in_data_a = {8'h44, 8'h33, 8'h22, 8'h5A};
        tick;
        chk("mid_load", 32'(out_data_a), 32'h5A);
        out_ready_a = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid_a), 32'd0);
        chk("mid_rst_data", 32'(out_data_a), 32'd0);
        chk("mid_rst_chan", 32'(out_chan_a), 32'd0);
        chk("mid_rst_ready", 32'(in_ready_a), 32'd0);
        out_ready_a = 1'b1;
        tick;
        chk("rst_no_handshake", 32'(out_valid_a), 32'd0);
        #2;
        reset = 1'b0;
        mode_a = 1'b1; in_valid_a = 4'b0110;
        #1;
        chk("ptr_after_rst", 32'(in_ready_a), 32'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
